// File: rtl/cadr_ddr_pkg.sv
// Shared types and constants for the CADR sdram to MiSTer DDRAM bridge.
package cadr_ddr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DONE,
        RELEASE
    } state_t;

    localparam logic [28:0] DDR_BASE_DEFAULT = 29'h0300_0000;

    localparam logic [7:0]  BE_LANE_LO = 8'h0F;
    localparam logic [7:0]  BE_LANE_HI = 8'hF0;
    localparam logic [7:0]  BE_ALL     = 8'hFF;

    localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/cadr_ddr_bridge.sv
// Registered request sequencer from the CADR sdram bus onto the MiSTer DDRAM Avalon port.
// Optional read-wait timeout is enabled with `define CADR_DDR_TIMEOUT_EN.
module cadr_ddr_bridge
    import cadr_ddr_pkg::*;
#(
    parameter logic [28:0] DDR_BASE       = DDR_BASE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [21:0] sdram_addr,
    input  logic [31:0] sdram_data_in,
    input  logic        sdram_req,
    input  logic        sdram_write,
    output logic [31:0] sdram_data_out,
    output logic        sdram_done,
    output logic        sdram_ready,
    output logic        ddr_timeout,

    output logic        DDRAM_CLK,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    state_t state;
    state_t state_next;
    logic   lane;
    logic   is_write;
    logic   tmo_hit;

    assign DDRAM_CLK      = clk;
    assign DDRAM_BURSTCNT = 8'd1;

`ifdef CADR_DDR_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit = (state == WAIT_RD) && (tmo_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset || state != WAIT_RD) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    // A real reply on the expiry cycle wins; only a true miss is flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            ddr_timeout <= 1'b0;
        end else if (tmo_hit && !DDRAM_DOUT_READY) begin
            ddr_timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign ddr_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sdram_req) state_next = ISSUE;
            ISSUE:   if (!DDRAM_BUSY) state_next = is_write ? DONE : WAIT_RD;
            WAIT_RD: if (DDRAM_DOUT_READY || tmo_hit) state_next = DONE;
            DONE:    state_next = RELEASE;
            RELEASE: if (!sdram_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            DDRAM_RD       <= 1'b0;
            DDRAM_WE       <= 1'b0;
            DDRAM_ADDR     <= '0;
            DDRAM_DIN      <= '0;
            DDRAM_BE       <= '0;
            lane           <= 1'b0;
            is_write       <= 1'b0;
            sdram_data_out <= '0;
            sdram_done     <= 1'b0;
            sdram_ready    <= 1'b0;
        end else begin
            sdram_done  <= 1'b0;
            sdram_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (sdram_req) begin
                        DDRAM_ADDR <= DDR_BASE + {8'b0, sdram_addr[21:1]};
                        DDRAM_DIN  <= {sdram_data_in, sdram_data_in};
                        DDRAM_BE   <= sdram_write ? (sdram_addr[0] ? BE_LANE_HI : BE_LANE_LO) : BE_ALL;
                        lane       <= sdram_addr[0];
                        is_write   <= sdram_write;
                        DDRAM_WE   <= sdram_write;
                        DDRAM_RD   <= !sdram_write;
                    end
                end
                ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        DDRAM_WE <= 1'b0;
                    end
                end
                WAIT_RD: begin
                    if (DDRAM_DOUT_READY) begin
                        sdram_data_out <= lane ? DDRAM_DOUT[63:32] : DDRAM_DOUT[31:0];
                    end else if (tmo_hit) begin
                        sdram_data_out <= TIMEOUT_PATTERN;
                    end
                end
                DONE: begin
                    sdram_done  <= 1'b1;
                    sdram_ready <= !is_write;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cadr_ddr_bridge.sv
// Directed scoreboard bench for cadr_ddr_bridge; the timeout case runs when CADR_DDR_TIMEOUT_EN is defined.
module tb_cadr_ddr_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] sdram_addr;
    logic [31:0] sdram_data_in;
    logic        sdram_req;
    logic        sdram_write;
    logic [31:0] sdram_data_out;
    logic        sdram_done;
    logic        sdram_ready;
    logic        ddr_timeout;
    logic        DDRAM_CLK;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    cadr_ddr_bridge #(
        .DDR_BASE       (29'h0300_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sdram_addr       (sdram_addr),
        .sdram_data_in    (sdram_data_in),
        .sdram_req        (sdram_req),
        .sdram_write      (sdram_write),
        .sdram_data_out   (sdram_data_out),
        .sdram_done       (sdram_done),
        .sdram_ready      (sdram_ready),
        .ddr_timeout      (ddr_timeout),
        .DDRAM_CLK        (DDRAM_CLK),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_WE         (DDRAM_WE)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction. lat = reply delay after acceptance (0 = never reply).
    task automatic txn(input string tag, input bit wr, input logic [21:0] a, input logic [31:0] d,
                       input int busy_n, input int lat, input logic [63:0] rdata,
                       input logic [28:0] exp_addr, input logic [7:0] exp_be,
                       input int exp_cycles, input int hold);
        int cycles = 0;
        int cmd_cycles = 0;
        int accepts = 0;
        int acc_cycle = 0;
        int stray = 0;
        bit got = 1'b0;
        logic [31:0] exp_data;
        if (!wr) exp_q.push_back(lat == 0 ? 32'hDEAD_BEEF : (a[0] ? rdata[63:32] : rdata[31:0]));
        sdram_addr = a; sdram_data_in = d; sdram_write = wr; sdram_req = 1'b1;
        while (!got && cycles < exp_cycles + 20) begin
            tick();
            cycles++;
            // master may change inputs after the latch; they must be ignored
            sdram_addr = ~a; sdram_data_in = ~d; sdram_write = ~wr;
            DDRAM_BUSY = (cycles <= busy_n);
            if (acc_cycle > 0 && lat > 0 && cycles == acc_cycle + lat) begin
                DDRAM_DOUT_READY = 1'b1; DDRAM_DOUT = rdata;
            end else begin
                DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = 64'hFFFF_0000_5555_0000;
            end
            if (DDRAM_RD || DDRAM_WE) begin
                cmd_cycles++;
                check({tag, "_addr"}, 64'(DDRAM_ADDR), 64'(exp_addr));
                check({tag, "_be"}, 64'(DDRAM_BE), 64'(exp_be));
                check({tag, "_cmd"}, {62'b0, DDRAM_WE, DDRAM_RD}, {62'b0, wr, !wr});
                if (wr) check({tag, "_din"}, DDRAM_DIN, {d, d});
                if (!DDRAM_BUSY) begin accepts++; acc_cycle = cycles; end
            end
            if (sdram_done) begin
                got = 1'b1;
                check({tag, "_ready"}, 64'(sdram_ready), 64'(!wr));
                if (!wr && exp_q.size() > 0) begin
                    exp_data = exp_q.pop_front();
                    check({tag, "_data"}, 64'(sdram_data_out), 64'(exp_data));
                end
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(cycles), 64'(exp_cycles));
        check({tag, "_accepts"}, 64'(accepts), 64'd1);
        check({tag, "_cmd_cycles"}, 64'(cmd_cycles), 64'(busy_n + 1));
        DDRAM_BUSY = 1'b0; DDRAM_DOUT_READY = 1'b0;
        for (int i = 0; i < hold + 1; i++) begin
            tick();
            if (DDRAM_RD || DDRAM_WE || sdram_done || sdram_ready) stray++;
        end
        check({tag, "_one_txn"}, 64'(stray), 64'd0);
        sdram_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; sdram_addr = '0; sdram_data_in = '0; sdram_req = 1'b0; sdram_write = 1'b0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
        tick(); tick();
        check("rst_rd", 64'(DDRAM_RD), 64'd0);
        check("rst_we", 64'(DDRAM_WE), 64'd0);
        check("rst_done", 64'(sdram_done), 64'd0);
        check("rst_ready", 64'(sdram_ready), 64'd0);
        check("rst_data", 64'(sdram_data_out), 64'd0);
        check("rst_timeout", 64'(ddr_timeout), 64'd0);
        check("rst_be", 64'(DDRAM_BE), 64'd0);
        check("rst_addr", 64'(DDRAM_ADDR), 64'd0);
        check("rst_din", DDRAM_DIN, 64'd0);
        check("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
        reset = 1'b0;
        tick();

        txn("wr_hi", 1'b1, 22'h000001, 32'h1234_5678, 0, 0, 64'd0, 29'h0300_0000, 8'hF0, 3, 0);
        txn("wr_lo", 1'b1, 22'h000010, 32'hA5A5_0F0F, 0, 0, 64'd0, 29'h0300_0008, 8'h0F, 3, 0);
        txn("rd_lo", 1'b0, 22'h000004, 32'h0, 0, 5, 64'hAAAA_BBBB_CCCC_DDDD, 29'h0300_0002, 8'hFF, 8, 0);
        txn("rd_busy", 1'b0, 22'h000005, 32'h0, 7, 2, 64'h1111_2222_3333_4444, 29'h0300_0002, 8'hFF, 12, 20);
        txn("rd_top", 1'b0, 22'h3FFFFF, 32'h0, 0, 1, 64'h0F0F_F0F0_0000_0001, 29'h031F_FFFF, 8'hFF, 4, 0);

        // stray reply while idle must not disturb the held read data
        DDRAM_DOUT = 64'h9999_8888_7777_6666; DDRAM_DOUT_READY = 1'b1;
        tick();
        DDRAM_DOUT_READY = 1'b0;
        tick();
        check("stray_data", 64'(sdram_data_out), 64'h0F0F_F0F0);
        check("stray_done", 64'(sdram_done | sdram_ready), 64'd0);

        // reset while waiting for a read reply
        sdram_addr = 22'h000002; sdram_write = 1'b0; sdram_req = 1'b1;
        tick(); tick(); tick();
        check("pre_rst_rd", 64'(DDRAM_RD), 64'd0);
        reset = 1'b1; sdram_req = 1'b0;
        tick();
        check("mid_rst_rd", 64'(DDRAM_RD), 64'd0);
        check("mid_rst_we", 64'(DDRAM_WE), 64'd0);
        check("mid_rst_done", 64'(sdram_done | sdram_ready), 64'd0);
        check("mid_rst_data", 64'(sdram_data_out), 64'd0);
        reset = 1'b0;
        tick();
        txn("rd_after_rst", 1'b0, 22'h000006, 32'h0, 0, 3, 64'h1357_9BDF_2468_ACE0, 29'h0300_0003, 8'hFF, 6, 0);

`ifdef CADR_DDR_TIMEOUT_EN
        txn("rd_tmo", 1'b0, 22'h000008, 32'h0, 0, 0, 64'd0, 29'h0300_0004, 8'hFF, 19, 0);
        check("tmo_flag", 64'(ddr_timeout), 64'd1);
        txn("wr_after_tmo", 1'b1, 22'h000009, 32'hCAFE_F00D, 0, 0, 64'd0, 29'h0300_0004, 8'hF0, 3, 0);
        check("tmo_sticky", 64'(ddr_timeout), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("tmo_cleared", 64'(ddr_timeout), 64'd0);
`else
        check("tmo_tied", 64'(ddr_timeout), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
